// File: rtl/mdu_iter.sv
//==============================================================================
// Module      : mdu_iter
// Description : Fixed-latency multiply/divide unit; commits to HI/LO after
//               MULT_CYCLES / DIV_CYCLES. Optional macro MDU_DIVZERO_DEF_EN
//               selects defined divide-by-zero results (LO=all ones, HI=A).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_iter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_done;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_phi;
    logic [31:0]          r_plo;
    logic                 r_pwe;

    logic                 w_accept;
    logic                 w_is_md;
    logic                 w_is_div;
    logic                 w_load;
    logic                 w_commit;
    logic                 w_divzero;

    logic [63:0]          w_smul;
    logic [63:0]          w_umul;
    logic [31:0]          w_b_safe;
    logic [31:0]          w_a_mag;
    logic [31:0]          w_b_mag;
    logic [31:0]          w_sq_mag;
    logic [31:0]          w_sr_mag;
    logic [31:0]          w_sq;
    logic [31:0]          w_sr;
    logic [31:0]          w_uq;
    logic [31:0]          w_ur;
    logic [31:0]          w_phi_nxt;
    logic [31:0]          w_plo_nxt;
    logic                 w_pwe_nxt;

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

    assign w_accept  = start & ~busy;
    assign w_is_div  = (MDUOp == c_OP_DIV) || (MDUOp == c_OP_DIVU);
    assign w_is_md   = (MDUOp == c_OP_MULT) || (MDUOp == c_OP_MULTU) || w_is_div;
    assign w_divzero = (B == 32'd0);

    // Sign-extended operands give the exact signed product in the low 64 bits.
    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_umul = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_b_safe = w_divzero ? 32'd1 : B;
    assign w_a_mag  = A[31] ? (32'd0 - A) : A;
    assign w_b_mag  = w_divzero ? 32'd1 : (B[31] ? (32'd0 - B) : B);
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (A[31] ^ B[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = A[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = A / w_b_safe;
    assign w_ur     = A % w_b_safe;

    always_comb begin
        w_phi_nxt = 32'd0;
        w_plo_nxt = 32'd0;
        w_pwe_nxt = 1'b1;
        if (w_is_div && w_divzero) begin
`ifdef MDU_DIVZERO_DEF_EN
            w_phi_nxt = A;
            w_plo_nxt = 32'hFFFF_FFFF;
`else
            w_pwe_nxt = 1'b0;
`endif
        end else begin
            case (MDUOp)
                c_OP_MULT:  {w_phi_nxt, w_plo_nxt} = w_smul;
                c_OP_MULTU: {w_phi_nxt, w_plo_nxt} = w_umul;
                c_OP_DIV: begin
                    w_phi_nxt = w_sr;
                    w_plo_nxt = w_sq;
                end
                c_OP_DIVU: begin
                    w_phi_nxt = w_ur;
                    w_plo_nxt = w_uq;
                end
                default: w_pwe_nxt = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_md) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_div ? c_DIV_LOAD : c_MULT_LOAD;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pwe   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_commit;
            if (w_load) begin
                r_phi <= w_phi_nxt;
                r_plo <= w_plo_nxt;
                r_pwe <= w_pwe_nxt;
            end
            // Commit only happens in RUN, moves only in IDLE: never both.
            if (w_commit) begin
                if (r_pwe) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end else if (w_accept) begin
                if (MDUOp == c_OP_MTHI) r_hi <= A;
                if (MDUOp == c_OP_MTLO) r_lo <= A;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
//==============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for mdu_iter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests;
    int fails;

    mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int cyc, dones, early;
        hi0 = HI; lo0 = LO; cyc = 0; dones = 0; early = 0;
        @(negedge clk); start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk); start = 1'b0; MDUOp = 3'b000;
        for (int i = 0; i < 40 && busy; i++) begin
            cyc++;
            if (HI !== hi0 || LO !== lo0) early++;
            if (done) dones++;
            @(negedge clk);
        end
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        tests++; if (cyc !== exp_cyc) begin fails++; $display("FAIL %s busy_cycles got %0d want %0d", name, cyc, exp_cyc); end
        tests++; if (early !== 0) begin fails++; $display("FAIL %s early_hilo got %0d want 0", name, early); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL %s done_pulses got %0d want 1", name, dones); end
        tests++; if (HI !== exp_hi) begin fails++; $display("FAIL %s HI got %h want %h", name, HI, exp_hi); end
        tests++; if (LO !== exp_lo) begin fails++; $display("FAIL %s LO got %h want %h", name, LO, exp_lo); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; MDUOp = 3'b000; A = '0; B = '0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done got %b want 0", done); end
        tests++; if (HI !== 32'd0) begin fails++; $display("FAIL reset HI got %h want 0", HI); end
        tests++; if (LO !== 32'd0) begin fails++; $display("FAIL reset LO got %h want 0", LO); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'b100, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("div_neg_divisor", 3'b011, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = LO;
        @(negedge clk); start = 1'b1; MDUOp = 3'b101; A = 32'h1234_5678;
        @(negedge clk);
        tests++; if (HI !== 32'h1234_5678) begin fails++; $display("FAIL mthi HI got %h want 12345678", HI); end
        tests++; if (LO !== lo0) begin fails++; $display("FAIL mthi LO got %h want %h", LO, lo0); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mthi busy/done got %b%b want 00", busy, done); end
        MDUOp = 3'b110; A = 32'h9ABC_DEF0;
        @(negedge clk);
        tests++; if (LO !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo LO got %h want 9abcdef0", LO); end
        tests++; if (HI !== 32'h1234_5678) begin fails++; $display("FAIL mtlo HI got %h want 12345678", HI); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mtlo busy/done got %b%b want 00", busy, done); end
        MDUOp = 3'b111; A = 32'hDEAD_BEEF;
        @(negedge clk);
        MDUOp = 3'b000;
        @(negedge clk); start = 1'b0;
        tests++; if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0 || busy !== 1'b0)
            begin fails++; $display("FAIL nop_op HI/LO/busy got %h %h %b want 12345678 9abcdef0 0", HI, LO, busy); end
`ifdef MDU_DIVZERO_DEF_EN
        run_op("div_by_zero", 3'b011, 32'h0000_0055, 32'd0, 10, 32'h0000_0055, 32'hFFFF_FFFF);
`else
        run_op("div_by_zero", 3'b011, 32'h0000_0055, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
`endif
    endtask

    task automatic test_busy_start_ignored();
        int cyc, extra;
        cyc = 0; extra = 0;
        @(negedge clk); start = 1'b1; MDUOp = 3'b001; A = 32'd3; B = 32'd4;
        @(negedge clk); start = 1'b0; MDUOp = 3'b000;
        for (int i = 0; i < 40 && busy; i++) begin
            cyc++;
            if (i == 1) begin start = 1'b1; MDUOp = 3'b011; A = 32'd100; B = 32'd7; end
            else begin start = 1'b0; MDUOp = 3'b000; end
            @(negedge clk);
        end
        start = 1'b0; MDUOp = 3'b000;
        tests++; if (cyc !== 5) begin fails++; $display("FAIL ignore busy_cycles got %0d want 5", cyc); end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy || HI !== 32'd0 || LO !== 32'd12) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL ignore late_activity got %0d want 0", extra); end
        tests++; if (LO !== 32'd12 || HI !== 32'd0) begin fails++; $display("FAIL ignore HI/LO got %h %h want 0 c", HI, LO); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); start = 1'b1; MDUOp = 3'b001; A = 32'd6; B = 32'd7;
        @(negedge clk); start = 1'b0; MDUOp = 3'b000;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b done/busy got %b%b want 10", done, busy); end
        start = 1'b1; MDUOp = 3'b010; A = 32'd2; B = 32'd3;
        @(negedge clk); start = 1'b0; MDUOp = 3'b000;
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b restart busy/done got %b%b want 10", busy, done); end
        tests++; if (LO !== 32'd42 || HI !== 32'd0) begin fails++; $display("FAIL b2b first HI/LO got %h %h want 0 2a", HI, LO); end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        tests++; if (LO !== 32'd6 || HI !== 32'd0) begin fails++; $display("FAIL b2b second HI/LO got %h %h want 0 6", HI, LO); end
    endtask

    task automatic test_reset_abort();
        int act;
        act = 0;
        @(negedge clk); start = 1'b1; MDUOp = 3'b011; A = 32'd100; B = 32'd7;
        @(negedge clk); start = 1'b0; MDUOp = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort busy/done got %b%b want 00", busy, done); end
        tests++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL abort HI/LO got %h %h want 0 0", HI, LO); end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || done || HI !== 32'd0 || LO !== 32'd0) act++;
        end
        tests++; if (act !== 0) begin fails++; $display("FAIL abort late_commit got %0d want 0", act); end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; start = 1'b0; MDUOp = 3'b000; A = '0; B = '0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_busy_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
